// File: rtl/shift_sequencer.sv
// Command sequencer driving s/P of a shift register and capturing D.
// Optional D-vs-model checker: define SHIFT_SEQ_CHECK_EN.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] P,
  output logic [1:0]       s,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] res_data,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign P         = data_q;
  assign s         = s_q;
  assign res_data  = res_q;
  assign done      = done_q;

  // Next state, latched command, and registered s/result/done.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    s_d     = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          cnt_d   = cmd_count;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = (cnt_q != '0) ? SHIFT : CAPTURE;
      end
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        res_d   = D;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      LOAD:    s_d = 2'd2;
      SHIFT:   s_d = dir_d ? 2'd3 : 2'd1;
      default: s_d = 2'd0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      s_q     <= 2'd0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

`ifdef SHIFT_SEQ_CHECK_EN
  logic [WIDTH-1:0] model_q, model_d;
  logic             err_q, err_d;

  // Shadow of the shift register; flag a sticky error on capture mismatch.
  always_comb begin
    model_d = model_q;
    err_d   = err_q;
    unique case (state_q)
      LOAD:  model_d = data_q;
      SHIFT: model_d = dir_q ? {model_q[WIDTH-2:0], 1'b0}
                             : {1'b0, model_q[WIDTH-1:1]};
      CAPTURE: if (D != model_q) err_d = 1'b1;
      default: ;
    endcase
  end

  // Model and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      model_q <= '0;
      err_q   <= 1'b0;
    end else begin
      model_q <= model_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with an attached shift register.
// Random and directed commands; results checked against shift arithmetic.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_dir = 1'b0;
  logic [2:0] cmd_count = 3'd0;
  logic [3:0] P;
  logic [1:0] s;
  logic [3:0] D;
  logic [3:0] res_data;
  logic       done;
  logic       busy;
  logic       err;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .P(P), .s(s), .D(D),
    .res_data(res_data), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached 4-bit shift register (no reset), logical zero-fill shifts.
  logic [3:0] sr;
  bit corrupt_active = 1'b0;
  always @(posedge clk) begin
    case (s)
      2'd1: sr <= sr >> 1;
      2'd2: sr <= P;
      2'd3: sr <= sr << 1;
      default: sr <= sr;
    endcase
  end
  assign D = (corrupt_active && busy && s == 2'd0) ? 4'hF : sr;

  typedef struct {
    logic [3:0] res;
    int         acc;
    int         cnt;
    bit         cor;
  } exp_t;
  typedef struct {
    logic [1:0] sv;
    logic [3:0] pv;
  } sx_t;

  exp_t sb[$];
  sx_t  sq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   exp_err = 1'b0;
  bit   prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
  endtask

  function automatic logic [3:0] ref_res(input logic [3:0] d,
                                         input logic dir, input int c);
    logic [7:0] w;
    w = {4'b0, d};
    w = dir ? (w << c) : (w >> c);
    return w[3:0];
  endfunction

  // Monitor: pops the expected s/P sequence while busy and results on done.
  always @(negedge clk) begin
    exp_t e;
    sx_t  x;
    chk("ready_vs_busy", cmd_ready, !busy);
    if (busy) begin
      if (sq.size() == 0) begin
        chk("s_seq_empty", 1, 0);
      end else begin
        x = sq.pop_front();
        chk("s_seq", s, x.sv);
        if (x.sv == 2'd2) chk("P_load", P, x.pv);
      end
    end
    if (done) begin
      chk("done_not_twice", prev_done, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.cor) exp_err = 1'b1;
        chk("res_data", res_data, e.res);
        chk("latency", cyc - e.acc, e.cnt + 2);
        chk("err", err, exp_err);
      end
    end
    prev_done = done;
  end

  task automatic send(input logic [3:0] d, input logic dir,
                      input int c, input bit hold, input bit cor);
    bit chained;
    int n;
    exp_t e;
    sx_t x;
    chained = cmd_valid;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = c[2:0];
    cmd_valid = 1'b1;
    if (cor) corrupt_active = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (chained) chk("b2b_accept_in_done", done, 1);
    e.res = cor ? 4'hF : ref_res(d, dir, c);
    e.acc = cyc + 1;
    e.cnt = c;
    e.cor = cor;
    sb.push_back(e);
    x.sv = 2'd2;
    x.pv = d;
    sq.push_back(x);
    for (int i = 0; i < c; i++) begin
      x.sv = dir ? 2'd3 : 2'd1;
      sq.push_back(x);
    end
    x.sv = 2'd0;
    sq.push_back(x);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_s"}, s, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res"}, res_data, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_P", P, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(4'b1010, 1'b0, 0, 1'b0, 1'b0);
    drain();
    send(4'b1010, 1'b0, 1, 1'b0, 1'b0);
    drain();
    send(4'b1010, 1'b0, 2, 1'b0, 1'b0);
    drain();
    send(4'b0011, 1'b1, 2, 1'b0, 1'b0);
    drain();
    send(4'b0011, 1'b1, 5, 1'b0, 1'b0);
    drain();

    send(4'b1001, 1'b1, 1, 1'b1, 1'b0);
    send(4'b0110, 1'b0, 3, 1'b0, 1'b0);
    drain();

`ifdef SHIFT_SEQ_CHECK_EN
    send(4'b1010, 1'b0, 1, 1'b0, 1'b1);
    drain();
    corrupt_active = 1'b0;
    send(4'b0101, 1'b1, 1, 1'b0, 1'b0);
    drain();
    send(4'b1100, 1'b0, 2, 1'b0, 1'b0);
    drain();
`endif

    for (int k = 0; k < 40; k++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      if (!cmd_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    cmd_valid = 1'b0;
    drain();

    send(4'b1111, 1'b1, 5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    sq.delete();
    exp_err = 1'b0;
    chk_idle("midreset");
    repeat (8) @(negedge clk);

    send(4'b0111, 1'b0, 1, 1'b0, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller that sits directly upstream of the 4-bit shift register (`P`, `s`, `clk` → `D`). It accepts a parallel word, a direction and a shift count over a valid/ready handshake, then drives `s`/`P` to load the word and shift it the requested number of times. It consumes the register's `D` output and returns the final word with a one-cycle `done` pulse. It replaces hand-sequenced `s` stimulus with a reusable stage for the datapath.

## Interface
- `WIDTH`, 4: data width; must equal the shift register width.
- `CNT_W`, 3: width of the shift-count field; maximum count is 2^CNT_W−1.

- `clk`  in  1  rising-edge clock; shared with the shift register.
- `rst_n`  in  1  reset, synchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command; high only in IDLE.
- `cmd_data`  in  WIDTH  word to load.
- `cmd_dir`  in  1  0 = shift right, 1 = shift left.
- `cmd_count`  in  CNT_W  number of shift steps after the load.
- `P`  out  WIDTH  parallel load value to the shift register.
- `s`  out  2  shift register mode: 0 hold, 1 shift right, 2 load, 3 shift left.
- `D`  in  WIDTH  shift register output.
- `res_data`  out  WIDTH  captured result; held until the next capture.
- `done`  out  1  one-cycle pulse when `res_data` updates.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky mismatch flag (see Configuration).

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE.
- IDLE:
  - `s`=0, `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch `cmd_data`, `cmd_dir` and `cmd_count`; go to LOAD.
- LOAD:
  - `s`=2 and `P`=latched data for exactly one cycle.
  - Next state: SHIFT if count≠0, else CAPTURE.
- SHIFT:
  - `s`=1 (dir 0) or 3 (dir 1).
  - The remaining-count register decrements every cycle; leave to CAPTURE after the cycle in which remaining=1.
- CAPTURE:
  - `s`=0.
  - `res_data`<=`D`, `done`<=1, then go to IDLE.
- `P` holds the last latched data outside LOAD. Its value matters only in LOAD.
- Commands arriving while `cmd_ready`=0 are not accepted. The upstream must hold `cmd_valid` and its fields stable until accepted.
- The shift register shifts logically with zero fill:
  - Right: `{0, D[WIDTH-1:1]}`.
  - Left: `{D[WIDTH-2:0], 0}`.
- Counts ≥ WIDTH therefore yield 0; this is legal and is not an error.
- Reset:
  - `rst_n`=0 at any edge forces IDLE.
  - All outputs go to: `s`=0, `P`=0, `res_data`=0, `done`=0, `busy`=0, `err`=0, `cmd_ready`=1 in the cycle after the reset edge.
  - The shift register has no reset; its contents stay undefined until the next LOAD.
  - A command in flight when reset arrives is abandoned, with no `done`.

## Timing
- All state, `s`, `P`, `res_data` and `done` are registered. `cmd_ready` and `busy` decode the state register.
- Accept edge = edge T. LOAD occupies cycle T..T+1; the shift register loads at edge T+1.
- Shift steps occur at edges T+2 … T+count+1.
- CAPTURE occupies the cycle ending at edge T+count+2; `done` is high for the following cycle.
- Accept-to-`done` latency is count+2 cycles; for count=0 it is 2.
- During the `done` cycle the state is IDLE and `cmd_ready`=1. A new command may be accepted at the edge ending the `done` cycle, giving back-to-back throughput of one command per count+3 cycles.
- `done` never asserts for two consecutive cycles.

## Configuration
- `SHIFT_SEQ_CHECK_EN` defined:
  - An internal model register mirrors the expected shift register contents: loaded in LOAD, shifted per the rules above in SHIFT.
  - In CAPTURE, if `D` ≠ model, `err` is set and stays set until `rst_n`=0.
  - `res_data` still captures `D` regardless of a mismatch.
- Macro not defined:
  - No model logic is present and `err` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release → `s`=0, `done`=0, `busy`=0, `cmd_ready`=1, `res_data`=0.
- Load-only: data=4'b1010, dir=0, count=0 → `s` sequence 2,0; `done` 2 cycles after accept; `res_data`=4'b1010.
- Right shift: data=4'b1010, dir=0, count=1 → `s` sequence 2,1,0; `done` at +3; `res_data`=4'b0101. Repeat with count=2 → `res_data`=4'b0010.
- Left shift and over-count:
  - data=4'b0011, dir=1, count=2 → `res_data`=4'b1100.
  - count=5 → `res_data`=4'b0000, `err`=0.
- Handshake: hold `cmd_valid`=1 with two queued commands → second accepted at the edge ending the first `done` cycle; `cmd_ready`=0 throughout LOAD/SHIFT/CAPTURE. Assert `rst_n`=0 mid-SHIFT → no `done`, IDLE next cycle.
- With `SHIFT_SEQ_CHECK_EN`: force `D` to 4'b1111 during CAPTURE of a data=4'b1010, count=1 command → `err`=1, and it stays 1 across later correct commands until reset.
